// File: rtl/cordic_mult_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier core among M requesters.
// Ports: clk, rst (async, active-high); req/req_a/req_b from requesters;
// done/res/busy/err back to requesters; core_start/core_a/core_b/core_c/core_rdy to the core.
// Optional watchdog on the core handshake: define CMARB_TIMEOUT_EN.
module cordic_mult_arbiter #(
  parameter int N   = 16,
  parameter int M   = 4,
  parameter int TMO = 40
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   req,
  input  logic [M*N-1:0] req_a,
  input  logic [M*N-1:0] req_b,
  output logic [M-1:0]   done,
  output logic [N-1:0]   res,
  output logic           busy,
  output logic           err,
  output logic           core_start,
  output logic [N-1:0]   core_a,
  output logic [N-1:0]   core_b,
  input  logic [N-1:0]   core_c,
  input  logic           core_rdy
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;

  if (M < 2 || M > 8 || TMO < 1) begin : g_bad_param
    $error("cordic_mult_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE, START, WAIT, DONE
  } state_t;

  state_t        state, nxt;
  logic [IW-1:0] ptr, idx, gidx;
  logic          gnt;
  logic          tmo_hit;

`ifdef CMARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt;
  logic          tmo_flag;

  // Expire on the TMO-th WAIT cycle so DONE lands TMO cycles after WAIT entry.
  assign tmo_hit = (state == WAIT) && !core_rdy &&
                   (cnt == CW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state == WAIT) begin
        cnt      <= cnt + 1'b1;
        tmo_flag <= tmo_hit;
      end else begin
        cnt      <= '0;
      end
      if (state == IDLE)
        tmo_flag <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // First set request at or above ptr, wrapping modulo M.
  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    for (int k = 0; k < M; k++) begin
      if (!gnt && req[(int'(ptr) + k) % M]) begin
        gnt  = 1'b1;
        gidx = IW'((int'(ptr) + k) % M);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (gnt) nxt = START;
      START: nxt = WAIT;
      WAIT:  if (core_rdy || tmo_hit) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    done       = '0;
    core_start = (state == START);
    busy       = (state != IDLE);
    if (state == DONE)
      done[idx] = 1'b1;
`ifdef CMARB_TIMEOUT_EN
    err = (state == DONE) && tmo_flag;
`else
    err = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      idx    <= '0;
      res    <= '0;
      core_a <= '0;
      core_b <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt) begin
            idx    <= gidx;
            core_a <= req_a[int'(gidx) * N +: N];
            core_b <= req_b[int'(gidx) * N +: N];
          end
        end
        WAIT: begin
          if (core_rdy)
            res <= core_c;
          else if (tmo_hit)
            res <= '0;
        end
        DONE: begin
          ptr <= (idx == IW'(M - 1)) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_mult_arbiter.sv
// Scoreboard bench for cordic_mult_arbiter with a behavioural multiplier stub
// (ready 17 cycles after start, product = (a*b)>>>15 truncated).
module tb_cordic_mult_arbiter;

  localparam int N = 16;
  localparam int M = 4;

  logic           clk = 0;
  logic           rst = 1;
  logic [M-1:0]   req = '0;
  logic [M*N-1:0] req_a, req_b;
  logic [M-1:0]   done;
  logic [N-1:0]   res;
  logic           busy, err, core_start;
  logic [N-1:0]   core_a, core_b;
  logic [N-1:0]   core_c = '0;
  logic           core_rdy = 0;

  cordic_mult_arbiter #(.N(N), .M(M), .TMO(40)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .done(done), .res(res), .busy(busy), .err(err),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_c(core_c), .core_rdy(core_rdy)
  );

  always #5 clk = ~clk;

  // Hand-computed operand / product table per requester.
  logic [15:0] ta [4] = '{16'h4000, 16'h8000, 16'h2000, 16'hC000};
  logic [15:0] tb [4] = '{16'h4000, 16'h7FFF, 16'h6000, 16'h4000};
  logic [15:0] tr [4] = '{16'h2000, 16'h8001, 16'h1800, 16'hE000};

  assign req_a = {ta[3], ta[2], ta[1], ta[0]};
  assign req_b = {tb[3], tb[2], tb[1], tb[0]};

  typedef struct {
    logic [3:0]  d;
    logic [15:0] r;
    bit          e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rdy_cyc = 0;
  int   nstart = 0;
  int   dcnt [4] = '{0, 0, 0, 0};
  bit   stub_en = 1;
  bit   spur = 0;
  int   timer = 0;
  logic [15:0] c_last = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic exp_push(input int i, input bit e);
    exp_t x;
    x.d = 4'(1 << i);
    x.r = e ? 16'h0 : tr[i];
    x.e = e;
    q.push_back(x);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Core stub.
  always @(negedge clk) begin
    logic signed [31:0] p;
    core_rdy = spur;
    if (rst) begin
      timer = 0;
    end else begin
      if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          p = $signed(core_a) * $signed(core_b);
          p = p >>> 15;
          core_c = p[15:0];
          c_last = core_c;
          core_rdy = 1'b1;
          rdy_cyc = cyc;
        end
      end
      if (core_start && stub_en)
        timer = 17;
    end
  end

  // Monitor / scoreboard.
  bit st_prev = 0;
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      st_prev = 0;
    end else begin
      if (core_start) begin
        chk("start_single_cycle", 32'(st_prev), 32'd0);
        start_cyc = cyc;
        nstart++;
      end
      st_prev = core_start;
      if (done != '0) begin
        for (int i = 0; i < 4; i++)
          if (done[i]) dcnt[i]++;
        chk("done_onehot", 32'($onehot(done)), 32'd1);
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          x = q.pop_front();
          chk("done_mask", 32'(done), 32'(x.d));
          chk("res", 32'(res), 32'(x.r));
          chk("err", 32'(err), 32'(x.e));
          if (x.e) begin
            chk("tmo_latency", 32'(cyc - start_cyc), 32'd41);
          end else begin
            chk("done_after_rdy", 32'(cyc - rdy_cyc), 32'd1);
            chk("done_latency", 32'(cyc - start_cyc), 32'd18);
            chk("res_bit_exact", 32'(res), 32'(c_last));
          end
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_res"}, 32'(res), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_start"}, 32'(core_start), 32'd0);
    chk({tag, "_core_a"}, 32'(core_a), 32'd0);
    chk({tag, "_core_b"}, 32'(core_b), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    req = '0;
    #1;
    chk_zero("reset");
    q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Requesters in m each hold req until served n times.
  task automatic serve(input logic [3:0] m, input int n);
    int pend [4];
    int lim;
    for (int i = 0; i < 4; i++) pend[i] = m[i] ? n : 0;
    req = m;
    lim = 0;
    while (req != '0 && lim < 3000) begin
      @(negedge clk);
      lim++;
      for (int i = 0; i < 4; i++) begin
        if (done[i] && pend[i] > 0) begin
          pend[i]--;
          if (pend[i] == 0) req[i] = 1'b0;
        end
      end
    end
    chk("serve_bound", 32'(req), 32'd0);
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s0, d1, d3, lim;
    bit bad;

    repeat (2) @(negedge clk);
    #1;
    chk_zero("por");
    @(negedge clk);
    rst = 0;

    // Single request, latency and operand routing.
    exp_push(0, 0);
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    chk("t031_start", 32'(core_start), 32'd1);
    chk("t031_core_a", 32'(core_a), 32'h4000);
    chk("t031_core_b", 32'(core_b), 32'h4000);
    chk("t031_busy", 32'(busy), 32'd1);
    serve(4'b0001, 1);

    // All four from reset: round-robin order 0,1,2,3.
    do_reset();
    s0 = nstart;
    for (int i = 0; i < 4; i++) exp_push(i, 0);
    serve(4'b1111, 1);
    chk("t032_starts", 32'(nstart - s0), 32'd4);

    // 0101 held: alternates 0,2,0,2; 1 and 3 never served.
    do_reset();
    d1 = dcnt[1];
    d3 = dcnt[3];
    exp_push(0, 0); exp_push(2, 0);
    exp_push(0, 0); exp_push(2, 0);
    serve(4'b0101, 2);
    chk("t033_no_done1", 32'(dcnt[1] - d1), 32'd0);
    chk("t033_no_done3", 32'(dcnt[3] - d3), 32'd0);

    // Reset mid-WAIT aborts; then 0100 served and ptr moves to 3.
    do_reset();
    exp_push(0, 0);
    req = 4'b0001;
    lim = 0;
    while (!core_start && lim < 20) begin
      @(negedge clk);
      lim++;
    end
    chk("t034_started", 32'(core_start), 32'd1);
    repeat (5) @(negedge clk);
    chk("t034_busy_wait", 32'(busy), 32'd1);
    rst = 1;
    #1;
    chk_zero("t034_abort");
    q.delete();
    req = 4'b0100;
    repeat (2) @(negedge clk);
    rst = 0;
    exp_push(2, 0);
    serve(4'b0100, 1);
    exp_push(3, 0);
    exp_push(0, 0);
    serve(4'b1001, 1);

    // Signed extreme operands.
    exp_push(1, 0);
    serve(4'b0010, 1);

    // core_rdy outside WAIT is ignored.
    spur = 1;
    repeat (3) @(negedge clk);
    chk("t020_idle_busy", 32'(busy), 32'd0);
    chk("t020_idle_done", 32'(done), 32'd0);
    exp_push(1, 0);
    req = 4'b0010;
    repeat (2) @(negedge clk);
    spur = 0;
    serve(4'b0010, 1);

    // Core never answers.
    do_reset();
    stub_en = 0;
`ifdef CMARB_TIMEOUT_EN
    exp_push(0, 1);
    serve(4'b0001, 1);
`else
    req = 4'b0001;
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy || done != '0 || err) bad = 1;
    end
    chk("t035_wait_forever", 32'(bad), 32'd0);
`endif
    stub_en = 1;
    do_reset();

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_mult_arbiter.md
CORDIC_MULT_ARBITER -- requirements
Module: cordic_mult_arbiter

Interface
REQ-001 SHALL have parameter N, default 16, operand/result width (signed, 0 integer bits, N-1 fractional bits).
REQ-002 SHALL have parameter M, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TMO, default 40, watchdog limit in clock cycles.
REQ-004 clk  input  1  clock; reset rst, asynchronous, active-high.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req  input  M  per-requester request level; requester i holds it with operands until done[i].
REQ-007 req_a / req_b  input  M*N each  operands; requester i occupies bits [i*N +: N].
REQ-008 done  output  M  one-hot, one-cycle completion pulse to the served requester.
REQ-009 res  output  N  result; valid in the done cycle and held until the next done.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 err  output  1  one-cycle watchdog-expiry pulse, coincident with done.
REQ-012 core_start  output  1  start strobe to the shared multiplier core.
REQ-013 core_a / core_b  output  N each  operands to the core, stable from START until return to IDLE.
REQ-014 core_c  input  N  core product.
REQ-015 core_rdy  input  1  core ready pulse.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT and DONE.
REQ-017 IDLE: if any req bit is set, SHALL grant the first set bit searching upward from pointer ptr (mod M), latch its index and operands, and go to START.
REQ-018 START: core_start SHALL be 1 for exactly this one cycle, then the FSM goes to WAIT.
REQ-019 WAIT: core_rdy SHALL be sampled only here; on core_rdy=1, core_c SHALL be captured into res and the FSM goes to DONE.
REQ-020 core_rdy asserted during IDLE or START SHALL be ignored.
REQ-021 DONE: done[idx] SHALL be 1 for one cycle, ptr SHALL become (idx+1) mod M, and the FSM goes to IDLE.
REQ-022 Latency: req sampled at cycle 0 -> core_start at cycle 1 -> done one cycle after the core_rdy cycle.
REQ-023 Minimum spacing between grants SHALL be 1 IDLE cycle; a req still high in that IDLE cycle counts as a new request.
REQ-024 If req[idx] drops mid-operation, the operation SHALL still complete and done[idx] still pulses.
REQ-025 Operands SHALL pass through unmodified (no sign extension or rounding); res SHALL equal core_c bit-exact.
REQ-026 core_start SHALL never be asserted while the FSM is in WAIT.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, ptr=0, done=0, res=0, busy=0, err=0, core_start=0, core_a=0, core_b=0, watchdog counter=0.
REQ-028 Reset mid-operation SHALL abort without a done pulse; pending requests are re-arbitrated from ptr=0.

Configuration
REQ-029 Macro CMARB_TIMEOUT_EN defined: a counter SHALL run in WAIT; after TMO cycles without core_rdy the FSM goes to DONE with res=0, err=1 and done[idx]=1.
REQ-030 Macro CMARB_TIMEOUT_EN undefined: WAIT SHALL last indefinitely, err SHALL be tied to 0, and no counter is present.

Verification
Bench uses a core stub: rdy 17 cycles after start, c=(a*b)>>>15 truncated, N=16, M=4.
REQ-031 req=0001, a=0x4000, b=0x4000 -> core_start at cycle 1, core_a=0x4000, done=0001 one cycle after rdy, res=0x2000.
REQ-032 req=1111 held from reset release -> done order 0001,0010,0100,1000, each exactly once per pass, 4 core_start pulses.
REQ-033 req=0101 held continuously -> grants alternate 0,2,0,2; bit 1 and bit 3 never get done.
REQ-034 rst pulse during WAIT -> all outputs 0 within the same cycle, no done; after release req=0100 -> served, ptr becomes 3.
REQ-035 Stub never asserts rdy, TMO=40 -> with macro: err=1 and done[i]=1 forty cycles after WAIT entry, res=0; without macro: busy stays 1 for 1000 cycles.
REQ-036 a=0x8000, b=0x7FFF -> res=0x8001, bit-exact to core_c.
